// File: rtl/spi_boot_sequencer_if.sv
// spi_boot_sequencer_if: bundles the image-load stream, the CPU-side SPI
// pins and the SPI RAM pins of spi_boot_sequencer.
//
// Load handshake: a byte transfers on a rising clk edge where
// load_valid && load_ready are both high. load_data and load_last must stay
// stable while load_valid is high and load_ready is low. load_ready never
// depends combinationally on load_valid.
interface spi_boot_sequencer_if;
  logic       load_req;
  logic [7:0] load_data;
  logic       load_valid;
  logic       load_last;
  logic       load_ready;
  logic       cpu_spi_select;
  logic       cpu_spi_out;
  logic       cpu_spi_clk_enable;
  logic       cpu_spi_data_in;
  logic       spi_select;
  logic       spi_out;
  logic       spi_clk_enable;
  logic       spi_data_in;

  // Sequencer side
  modport slave (
    input  load_req, load_data, load_valid, load_last,
    output load_ready,
    input  cpu_spi_select, cpu_spi_out, cpu_spi_clk_enable,
    output cpu_spi_data_in,
    output spi_select, spi_out, spi_clk_enable,
    input  spi_data_in
  );

  // Image source, CPU and RAM side
  modport master (
    output load_req, load_data, load_valid, load_last,
    input  load_ready,
    output cpu_spi_select, cpu_spi_out, cpu_spi_clk_enable,
    input  cpu_spi_data_in,
    input  spi_select, spi_out, spi_clk_enable,
    output spi_data_in
  );
endinterface

// File: rtl/spi_boot_sequencer.sv
// spi_boot_sequencer: holds the nanoV CPU in reset, sets the shared SPI RAM
// to sequential mode, optionally streams a program image into RAM, then
// releases the CPU and hands the SPI pins to it.
// Optional image loading is built only when the macro BOOT_LOAD_EN is defined.
// state_dbg exposes the FSM state encoding.
module spi_boot_sequencer #(
  parameter int unsigned GAP_CYCLES = 4,
  parameter logic [23:0] LOAD_BASE  = 24'h000000
) (
  input  logic                 clk,
  input  logic                 rstn,
  output logic                 cpu_rstn,
  output logic                 busy,
  input  logic                 cpu_restart,
  output logic [2:0]           state_dbg,
  spi_boot_sequencer_if.slave  io
);

  typedef enum logic [2:0] {
    S_INIT_GAP = 3'd0,
    S_INIT     = 3'd1,
    S_GAP      = 3'd2,
    S_HDR      = 3'd3,
    S_DATA     = 3'd4,
    S_END_GAP  = 3'd5,
    S_RUN      = 3'd6
  } state_t;

  localparam logic [4:0] GAP_LAST = 5'(GAP_CYCLES - 1);

  state_t      state;
  logic [4:0]  cnt;
  logic [31:0] shreg;
  logic        sel_q;
  logic        cke_q;
  logic        cpu_rstn_q;
  logic        busy_q;
  logic        seq_out;
`ifdef BOOT_LOAD_EN
  logic [2:0]  bit_cnt;   // bits still to shift after the current one
  logic        rdy_q;
  logic        last_q;
`endif

  // Sequencer FSM with all pin controls registered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= S_INIT_GAP;
      cnt        <= '0;
      shreg      <= '0;
      sel_q      <= 1'b1;
      cke_q      <= 1'b0;
      cpu_rstn_q <= 1'b0;
      busy_q     <= 1'b1;
`ifdef BOOT_LOAD_EN
      bit_cnt    <= '0;
      rdy_q      <= 1'b0;
      last_q     <= 1'b0;
`endif
    end else begin
      case (state)
        S_INIT_GAP: begin
          if (cnt == GAP_LAST) begin
            state <= S_INIT;
            cnt   <= '0;
            shreg <= {16'h0000, 16'h0140};
            sel_q <= 1'b0;
            cke_q <= 1'b1;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_INIT: begin
          shreg <= shreg << 1;
          if (cnt == 5'd15) begin
            state <= S_GAP;
            cnt   <= '0;
            sel_q <= 1'b1;
            cke_q <= 1'b0;
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
        S_GAP, S_END_GAP: begin
          if (cnt == GAP_LAST) begin
`ifdef BOOT_LOAD_EN
            if (state == S_GAP && io.load_req) begin
              state <= S_HDR;
              cnt   <= '0;
              shreg <= {8'h02, LOAD_BASE};
              sel_q <= 1'b0;
              cke_q <= 1'b1;
            end else begin
`else
            begin
`endif
              state      <= S_RUN;
              cpu_rstn_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end else begin
            cnt <= cnt + 5'd1;
          end
        end
`ifdef BOOT_LOAD_EN
        S_HDR: begin
          shreg <= shreg << 1;
          cnt   <= cnt + 5'd1;
          // Offer the first byte during the last header bit so data follows
          // the header without a dead cycle.
          rdy_q <= (cnt == 5'd30);
          if (cnt == 5'd31) begin
            state <= S_DATA;
            if (io.load_valid && rdy_q) begin
              shreg[7:0] <= io.load_data;
              last_q     <= io.load_last;
              bit_cnt    <= 3'd7;
              cke_q      <= 1'b1;
              rdy_q      <= 1'b0;
            end else begin
              cke_q <= 1'b0;
              rdy_q <= 1'b1;
            end
          end
        end
        S_DATA: begin
          if (cke_q && bit_cnt != 3'd0) begin
            shreg   <= shreg << 1;
            bit_cnt <= bit_cnt - 3'd1;
            rdy_q   <= (bit_cnt == 3'd1) && !last_q;
          end else if (cke_q && last_q) begin
            state <= S_END_GAP;
            cnt   <= '0;
            sel_q <= 1'b1;
            cke_q <= 1'b0;
            rdy_q <= 1'b0;
          end else if (io.load_valid && rdy_q) begin
            shreg[7:0] <= io.load_data;
            last_q     <= io.load_last;
            bit_cnt    <= 3'd7;
            cke_q      <= 1'b1;
            rdy_q      <= 1'b0;
          end else begin
            // Stall: select stays low, clock stops until a byte arrives
            cke_q <= 1'b0;
            rdy_q <= 1'b1;
          end
        end
`endif
        S_RUN: begin
          if (cpu_restart) begin
            // Counter starts one below zero so the CPU sees one extra reset
            // cycle beyond the gap (GAP_CYCLES + 1 in total).
            state      <= S_GAP;
            cnt        <= 5'h1f;
            sel_q      <= 1'b1;
            cke_q      <= 1'b0;
            cpu_rstn_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        default: state <= S_INIT_GAP;
      endcase
    end
  end

  // Serial data bit taken from the top of the active command field
  always_comb begin
    seq_out = 1'b0;
    case (state)
      S_INIT:  seq_out = shreg[15];
      S_HDR:   seq_out = shreg[31];
      S_DATA:  seq_out = shreg[7];
      default: seq_out = 1'b0;
    endcase
  end

  assign io.spi_select     = (state == S_RUN) ? io.cpu_spi_select     : sel_q;
  assign io.spi_out        = (state == S_RUN) ? io.cpu_spi_out        : seq_out;
  assign io.spi_clk_enable = (state == S_RUN) ? io.cpu_spi_clk_enable : cke_q;
  assign io.cpu_spi_data_in = io.spi_data_in;
  assign cpu_rstn  = cpu_rstn_q;
  assign busy      = busy_q;
  assign state_dbg = state;

`ifdef BOOT_LOAD_EN
  assign io.load_ready = rdy_q;
`else
  logic unused_load;
  assign unused_load = ^{io.load_req, io.load_data, io.load_valid, io.load_last};
  assign io.load_ready = 1'b0;
`endif

endmodule

// File: tb/tb_spi_boot_sequencer.sv
// tb_spi_boot_sequencer: directed bench for spi_boot_sequencer with
// GAP_CYCLES=4, LOAD_BASE=0. Load scenarios are selected by BOOT_LOAD_EN.
module tb_spi_boot_sequencer;

  localparam int RUN_BUDGET = 400;

  logic clk;
  logic rstn;
  logic cpu_rstn;
  logic busy;
  logic cpu_restart;
  logic [2:0] state_dbg;

  spi_boot_sequencer_if io();

  spi_boot_sequencer #(.GAP_CYCLES(4), .LOAD_BASE(24'h000000)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .cpu_rstn    (cpu_rstn),
    .busy        (busy),
    .cpu_restart (cpu_restart),
    .state_dbg   (state_dbg),
    .io          (io)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int checks;
  int failures;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] img [3];
  int r_first_run;
  int r_first_cke;
  int r_sel_low;
  int r_stall;
  logic r_rdy_seen;

  // Driver: resets the DUT, then runs one boot, sampling each cycle at
  // negedge+1 (k = number of rising edges since reset release). Captures
  // serial bytes and streams img[] when req is set. hold = cycles the
  // second byte is withheld once the sequencer is ready for it.
  task automatic run_boot(input logic req, input int hold, input int abort_k, input int restart_k);
    logic [7:0] sh;
    int nb;
    int idx;
    int wh;
    logic prev_fire;
    int acc_k;
    logic acc_last;
    rstn = 1'b0;
    io.load_req = 1'b0;
    io.load_valid = 1'b0;
    io.load_data = 8'h00;
    io.load_last = 1'b0;
    cpu_restart = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    sh = 8'h00; nb = 0; idx = 0; wh = 0; prev_fire = 1'b0; acc_k = -100; acc_last = 1'b0;
    got_q.delete();
    r_first_run = -1; r_first_cke = -1; r_sel_low = 0; r_stall = 0; r_rdy_seen = 1'b0;
    for (int k = 0; k < RUN_BUDGET; k++) begin
      #1;
      if (k == abort_k) begin
        rstn = 1'b0;
        return;
      end
      if (cpu_rstn) begin
        r_first_run = k;
        cpu_restart = 1'b0;
        io.load_valid = 1'b0;
        return;
      end
      if (busy && io.spi_clk_enable && !io.spi_select) begin
        if (r_first_cke < 0) r_first_cke = k;
        sh = {sh[6:0], io.spi_out};
        nb++;
        if (nb == 8) begin
          got_q.push_back(sh);
          nb = 0;
        end
      end
      if (busy && !io.spi_select) begin
        r_sel_low++;
        if (!io.spi_clk_enable) r_stall++;
      end
      if (io.load_ready) r_rdy_seen = 1'b1;
      if (prev_fire) begin
        acc_k = k - 1;
        acc_last = io.load_last;
        idx++;
        wh = (idx == 1) ? hold : 0;
      end
      if (k == acc_k + 1) begin
        checks++;
        if (io.load_ready !== 1'b0) begin
          failures++;
          $display("FAIL ready_drop: k=%0d load_ready=%b expected 0", k, io.load_ready);
        end
      end
      if (k == acc_k + 8 && !acc_last) begin
        checks++;
        if (io.load_ready !== 1'b1) begin
          failures++;
          $display("FAIL ready_rise: k=%0d load_ready=%b expected 1", k, io.load_ready);
        end
      end
      io.load_req = req;
      io.load_valid = req && (idx < 3) && (wh == 0);
      if (req && idx < 3 && wh > 0 && io.load_ready) wh--;
      io.load_data = (idx < 3) ? img[idx] : 8'h00;
      io.load_last = (idx == 2);
      prev_fire = io.load_valid && io.load_ready;
      cpu_restart = (k == restart_k);
      @(negedge clk);
    end
  endtask

  // Reset values, then plain boot (with an ignored restart pulse during INIT)
  task automatic test_reset();
    logic [7:0] e;
    logic [7:0] g;
    rstn = 1'b0;
    @(negedge clk);
    #1;
    checks++; if (cpu_rstn !== 1'b0) begin failures++; $display("FAIL rst_cpu_rstn: got %b expected 0", cpu_rstn); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rst_busy: got %b expected 1", busy); end
    checks++; if (io.load_ready !== 1'b0) begin failures++; $display("FAIL rst_load_ready: got %b expected 0", io.load_ready); end
    checks++; if (io.spi_select !== 1'b1) begin failures++; $display("FAIL rst_select: got %b expected 1", io.spi_select); end
    checks++; if (io.spi_out !== 1'b0) begin failures++; $display("FAIL rst_spi_out: got %b expected 0", io.spi_out); end
    checks++; if (io.spi_clk_enable !== 1'b0) begin failures++; $display("FAIL rst_clk_enable: got %b expected 0", io.spi_clk_enable); end
    checks++; if (state_dbg !== 3'd0) begin failures++; $display("FAIL rst_state: got %0d expected 0", state_dbg); end
    run_boot(1'b0, 0, -1, 8);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h40);
    checks++; if (r_first_cke !== 4) begin failures++; $display("FAIL boot_first_bit: got %0d expected 4", r_first_cke); end
    checks++; if (r_first_run !== 24) begin failures++; $display("FAIL boot_cpu_rstn_rise: got %0d expected 24", r_first_run); end
    checks++; if (r_sel_low !== 16) begin failures++; $display("FAIL boot_select_low: got %0d expected 16", r_sel_low); end
    checks++; if (r_stall !== 0) begin failures++; $display("FAIL boot_stall: got %0d expected 0", r_stall); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL boot_byte_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL boot_byte: got %02h expected %02h", g, e); end
    end
    exp_q.delete();
  endtask

  // CPU pins pass straight through in RUN
  task automatic test_passthrough();
    logic [3:0] got;
    logic [3:0] want;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy: got %b expected 0", busy); end
    for (int v = 0; v < 8; v++) begin
      want = {v[2], v[1], v[0], ~v[0]};
      io.cpu_spi_select = want[3];
      io.cpu_spi_out = want[2];
      io.cpu_spi_clk_enable = want[1];
      io.spi_data_in = want[0];
      #1;
      got = {io.spi_select, io.spi_out, io.spi_clk_enable, io.cpu_spi_data_in};
      checks++; if (got !== want) begin failures++; $display("FAIL passthrough: got %b expected %b", got, want); end
    end
    io.cpu_spi_select = 1'b1;
    io.cpu_spi_out = 1'b0;
    io.cpu_spi_clk_enable = 1'b0;
    @(negedge clk);
  endtask

  // Restart from RUN: CPU held for GAP_CYCLES+1, no SPI traffic
  task automatic test_restart();
    int low;
    int traffic;
    #1;
    cpu_restart = 1'b1;
    @(negedge clk);
    #1;
    cpu_restart = 1'b0;
    checks++; if (cpu_rstn !== 1'b0) begin failures++; $display("FAIL restart_cpu_rstn: got %b expected 0", cpu_rstn); end
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL restart_busy: got %b expected 1", busy); end
    checks++; if (io.spi_select !== 1'b1) begin failures++; $display("FAIL restart_select: got %b expected 1", io.spi_select); end
    checks++; if (state_dbg !== 3'd2) begin failures++; $display("FAIL restart_state: got %0d expected 2", state_dbg); end
    low = 1;
    traffic = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      #1;
      if (cpu_rstn) break;
      low++;
      if (io.spi_clk_enable || !io.spi_select) traffic++;
    end
    checks++; if (low !== 5) begin failures++; $display("FAIL restart_low_cycles: got %0d expected 5", low); end
    checks++; if (traffic !== 0) begin failures++; $display("FAIL restart_traffic: got %0d expected 0", traffic); end
  endtask

`ifdef BOOT_LOAD_EN
  // Three bytes back-to-back, or with the second byte withheld 10 cycles
  task automatic test_load(input int hold);
    logic [7:0] e;
    logic [7:0] g;
    run_boot(1'b1, hold, -1, -1);
    exp_q.push_back(8'h01); exp_q.push_back(8'h40);
    exp_q.push_back(8'h02); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
    exp_q.push_back(8'hA5); exp_q.push_back(8'h3C); exp_q.push_back(8'hFF);
    checks++; if (r_first_run !== 84 + hold) begin failures++; $display("FAIL load_cpu_rstn_rise: got %0d expected %0d", r_first_run, 84 + hold); end
    checks++; if (r_stall !== hold) begin failures++; $display("FAIL load_stall: got %0d expected %0d", r_stall, hold); end
    checks++; if (r_sel_low !== 72 + hold) begin failures++; $display("FAIL load_select_low: got %0d expected %0d", r_sel_low, 72 + hold); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL load_byte_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL load_byte: got %02h expected %02h", g, e); end
    end
    exp_q.delete();
  endtask
  localparam int ABORT_K = 60;
`else
  // Load request without the load feature: no header, ready stays low
  task automatic test_no_load();
    logic [7:0] e;
    logic [7:0] g;
    run_boot(1'b1, 0, -1, -1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h40);
    checks++; if (r_first_run !== 24) begin failures++; $display("FAIL noload_cpu_rstn_rise: got %0d expected 24", r_first_run); end
    checks++; if (r_rdy_seen !== 1'b0) begin failures++; $display("FAIL noload_ready: got %b expected 0", r_rdy_seen); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL noload_byte_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL noload_byte: got %02h expected %02h", g, e); end
    end
    exp_q.delete();
  endtask
  localparam int ABORT_K = 10;
`endif

  // Reset mid-transfer forces the pins safe at once, then INIT repeats
  task automatic test_reset_mid();
    logic [7:0] e;
    logic [7:0] g;
    run_boot(1'b1, 0, ABORT_K, -1);
    #1;
    checks++; if (io.spi_select !== 1'b1) begin failures++; $display("FAIL mid_select: got %b expected 1", io.spi_select); end
    checks++; if (cpu_rstn !== 1'b0) begin failures++; $display("FAIL mid_cpu_rstn: got %b expected 0", cpu_rstn); end
    checks++; if (io.spi_clk_enable !== 1'b0) begin failures++; $display("FAIL mid_clk_enable: got %b expected 0", io.spi_clk_enable); end
    checks++; if (io.load_ready !== 1'b0) begin failures++; $display("FAIL mid_load_ready: got %b expected 0", io.load_ready); end
    run_boot(1'b0, 0, -1, -1);
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h40);
    checks++; if (r_first_cke !== 4) begin failures++; $display("FAIL mid_reinit_first_bit: got %0d expected 4", r_first_cke); end
    checks++; if (r_first_run !== 24) begin failures++; $display("FAIL mid_reinit_rise: got %0d expected 24", r_first_run); end
    checks++; if (got_q.size() !== exp_q.size()) begin failures++; $display("FAIL mid_reinit_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++; if (g !== e) begin failures++; $display("FAIL mid_reinit_byte: got %02h expected %02h", g, e); end
    end
    exp_q.delete();
  endtask

  // Test sequence and final report
  initial begin
    checks = 0;
    failures = 0;
    img[0] = 8'hA5;
    img[1] = 8'h3C;
    img[2] = 8'hFF;
    rstn = 1'b0;
    cpu_restart = 1'b0;
    io.load_req = 1'b0;
    io.load_data = 8'h00;
    io.load_valid = 1'b0;
    io.load_last = 1'b0;
    io.cpu_spi_select = 1'b1;
    io.cpu_spi_out = 1'b0;
    io.cpu_spi_clk_enable = 1'b0;
    io.spi_data_in = 1'b0;
    test_reset();
    test_passthrough();
    test_restart();
`ifdef BOOT_LOAD_EN
    test_load(0);
    test_load(10);
`else
    test_no_load();
`endif
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_boot_sequencer.md
# spi_boot_sequencer

Sequences the shared SPI RAM ahead of and around the nanoV CPU. After reset, it holds the CPU in reset and puts the RAM into sequential mode. It can then stream a host-supplied program image into RAM before releasing the CPU and handing the SPI pins over to it. It sits between the CPU's SPI pins (select, out, clk_enable, data_in) and the top-level SPI pins.

## Interface
Parameters:
- GAP_CYCLES, 4: deselect cycles (select high, clock disabled) between SPI transactions; legal range 1..15
- LOAD_BASE, 24'h000000: 24-bit RAM address where a program image is written

Ports:
- clk  in  1  system clock; also the SPI clock when spi_clk_enable=1
- rstn  in  1  reset, asynchronous, active-low
- cpu_rstn  out  1  reset to CPU, active-low, registered
- busy  out  1  high in every state except RUN
- cpu_restart  in  1  single-cycle pulse; only honoured in RUN
- load_req  in  1  request image load; sampled when leaving a GAP
- load_data  in  8  image byte, shifted MSB first
- load_valid  in  1  load_data valid
- load_last  in  1  qualifies the final byte; sampled with load_data
- load_ready  out  1  byte accepted when load_valid && load_ready
- cpu_spi_select, cpu_spi_out, cpu_spi_clk_enable  in  1 each  CPU SPI outputs
- cpu_spi_data_in  out  1  equals spi_data_in at all times
- spi_select, spi_out, spi_clk_enable  out  1 each  pins to SPI RAM
- spi_data_in  in  1  SPI RAM MISO

## Operation
- One bit moves per clk while spi_clk_enable=1. Data is MSB first, and spi_out is driven from bit 31/15/7 of the sequencer's shift register.
- States: INIT_GAP, INIT, GAP, HDR, DATA, END_GAP, RUN.
- INIT_GAP:
  - Hold for GAP_CYCLES cycles with select=1, clk_enable=0.
  - Then go to INIT.
- INIT:
  - Hold for 16 cycles with select=0, clk_enable=1, shifting 16'h0140 (write mode register, sequential mode).
  - Then go to GAP.
- GAP:
  - Hold for GAP_CYCLES cycles with select=1.
  - On the last cycle: load_req=1 → HDR; otherwise → RUN.
- HDR:
  - Hold for 32 cycles with select=0, shifting {8'h02, LOAD_BASE}.
  - Then go to DATA.
- DATA:
  - select=0.
  - load_ready=1 when the byte bit counter is 0 (no byte in flight).
  - On accept, shift 8 bits with clk_enable=1.
  - If no byte is available at a byte boundary, clk_enable=0 and select stays low. This stall has unbounded length.
  - After the byte flagged load_last finishes shifting, go to END_GAP.
- END_GAP:
  - Same as GAP, then go to RUN unconditionally.
- RUN:
  - spi_select/spi_out/spi_clk_enable = cpu_spi_* combinationally.
  - cpu_rstn is registered 1 from the first RUN cycle.
- cpu_restart in RUN:
  - Next cycle: cpu_rstn=0, busy=1, state=GAP, and the pins revert to the sequencer (select=1).
  - INIT is not repeated.
  - cpu_restart outside RUN is ignored.
- The sequencer does not track addresses; the RAM wraps in sequential mode.
- An image of at least one byte is required. load_last on the first byte gives a 1-byte image.

## Timing
- Reset values:
  - cpu_rstn=0, busy=1, load_ready=0
  - spi_select=1, spi_out=0, spi_clk_enable=0
  - state=INIT_GAP, all counters 0
- While not in RUN, select and clock enable are registered. spi_out is valid in every cycle where clk_enable=1.
- Minimum time from reset release to cpu_rstn=1, with no load: 2·GAP_CYCLES + 16 cycles.
- Load path, for N bytes presented back-to-back:
  - load_ready drops the cycle after an accept and rises again 8 cycles after the accept.
  - Total time is 3·GAP_CYCLES + 48 + 8N + (stall cycles).
- Simultaneous load_valid with load_ready low: no accept; the byte must be held by the source.
- Reset asserted mid-operation: outputs go asynchronously to their reset values, and any transaction in progress is aborted with select=1.

## Configuration
- BOOT_LOAD_EN defined: behaviour as above.
- BOOT_LOAD_EN undefined:
  - HDR, DATA and END_GAP are not built.
  - load_req, load_data, load_valid and load_last are ignored.
  - load_ready is tied to 0.
  - GAP always goes to RUN.

## Test plan
- Reset release, load_req=0, GAP_CYCLES=4:
  - spi_out carries 0x0140 over cycles 4..19 with select low.
  - cpu_rstn rises at cycle 24.
  - After that, CPU pins pass through.
- load_req=1, three bytes A5,3C,FF streamed back-to-back with load_last on FF:
  - spi_out carries 0x02000000 then A5 3C FF, with no gaps.
  - RUN follows after GAP_CYCLES.
- load_valid dropped for 10 cycles between byte 1 and byte 2:
  - spi_clk_enable=0 and select=0 for exactly those cycles.
  - Bitstream unchanged.
- cpu_restart pulse in RUN with load_req=0:
  - cpu_rstn low for GAP_CYCLES+1 cycles.
  - No mode-register command is issued.
- rstn asserted during DATA mid-byte:
  - spi_select=1 and cpu_rstn=0 immediately.
  - After release, the full INIT sequence repeats.
- BOOT_LOAD_EN undefined with load_req=1:
  - No HDR is sent.
  - load_ready stays 0.
